dct_entdaa_writer: RTL

//  Captures per-device ENTDAA results (48-bit PID, BCR, DCR, assigned dynamic address) from the

---
 rtl/dct_entdaa_writer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/dct_entdaa_writer.sv
// ----------------------------------------------------------------------------
// dct_entdaa_writer
//
// Collects the per-device results of an ENTDAA sequence (48-bit PID, BCR, DCR
// and the assigned dynamic address). Each device's results are packed into one
// 128-bit Device Characteristic Table entry. The entry is written through the
// hardware DCT write port of the downstream DAT/DCT table block. One entry is
// written per device, at consecutive indices starting from a base index. The
// index wraps modulo DCT_SIZE.
//
// Ports
//   clk_i              clock
//   rst_i              synchronous active-high reset
//   daa_start_i        pulse: new ENTDAA sequence (clears count, latches base)
//   dct_index_base_i   first DCT index of the sequence
//   dev_start_i        pulse: arbitration for the next device begins
//   byte_valid_i       byte_i carries a received PID/BCR/DCR byte
//   byte_i             received byte, MSB-first bus order
//   da_valid_i         pulse: dynamic address assigned and ACKed
//   da_i               assigned dynamic address
//   abort_i            pulse: arbitration lost / NACK, drop current device
//   dct_write_valid_o  one-cycle DCT write strobe
//   dct_index_o        DCT entry index (held between writes)
//   dct_wdata_o        packed DCT entry (held between writes)
//   busy_o             high whenever the FSM is not idle
//   dev_count_o        entries written in this sequence
//   full_o             dev_count_o == DCT_SIZE
//
// Handshake: all inputs are single-cycle qualifiers. They have no ready
// back-pressure. An input that is not legal in the current state is dropped.
// dct_write_valid_o is a one-cycle strobe with no ready. The table block
// accepts it unconditionally.
// ----------------------------------------------------------------------------
module dct_entdaa_writer #(
    parameter int DCT_SIZE = 128,
    parameter int IW       = $clog2(DCT_SIZE)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          daa_start_i,
    input  logic [IW-1:0] dct_index_base_i,
    input  logic          dev_start_i,
    input  logic          byte_valid_i,
    input  logic [7:0]    byte_i,
    input  logic          da_valid_i,
    input  logic [6:0]    da_i,
    input  logic          abort_i,
    output logic          dct_write_valid_o,
    output logic [IW-1:0] dct_index_o,
    output logic [127:0]  dct_wdata_o,
    output logic          busy_o,
    output logic [IW:0]   dev_count_o,
    output logic          full_o
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] WAIT_DA = 2'd2;
    localparam logic [1:0] WRITE   = 2'd3;

    localparam logic [IW:0] SIZE_W = (IW+1)'(DCT_SIZE);
    localparam logic [IW:0] ONE_W  = (IW+1)'(1);

    logic [1:0]    state_q, state_d;
    logic [2:0]    byte_cnt_q, byte_cnt_d;
    logic [63:0]   shift_q, shift_d;
    logic [IW-1:0] base_q, base_d;
    logic [IW:0]   count_q, count_d;
    logic          wvalid_q, wvalid_d;
    logic [IW-1:0] index_q, index_d;
    logic [127:0]  wdata_q, wdata_d;

    logic          full;
    logic [IW:0]   idx_sum;
    logic [IW:0]   idx_wrap;
    logic [127:0]  packed_entry;

    assign full = (count_q == SIZE_W);

    // base < DCT_SIZE and count < DCT_SIZE whenever a write is possible.
    // A single conditional subtract is therefore enough for the modulo.
    assign idx_sum  = {1'b0, base_q} + count_q;
    assign idx_wrap = (idx_sum >= SIZE_W) ? (idx_sum - SIZE_W) : idx_sum;

    // shift_q after 8 bytes: [63:16] PID, [15:8] BCR, [7:0] DCR
    assign packed_entry = {24'h0, 1'b0, da_i, 16'h0, shift_q[15:8], shift_q[7:0],
                           16'h0, shift_q[31:16], shift_q[63:32]};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        base_d     = base_q;
        count_d    = count_q;
        wvalid_d   = 1'b0;
        index_d    = index_q;
        wdata_d    = wdata_q;
        if (daa_start_i) begin
            // The strobe of a WRITE in this cycle is already on the port.
            // Only the count update is superseded.
            state_d    = IDLE;
            byte_cnt_d = 3'd0;
            count_d    = '0;
            base_d     = dct_index_base_i;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dev_start_i && !full) begin
                        state_d    = COLLECT;
                        byte_cnt_d = 3'd0;
                    end
                end
                COLLECT: begin
                    if (abort_i) begin
                        state_d    = IDLE;
                        byte_cnt_d = 3'd0;
                    end else if (dev_start_i) begin
                        byte_cnt_d = 3'd0;
                    end else if (byte_valid_i) begin
                        shift_d    = {shift_q[55:0], byte_i};
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        if (byte_cnt_q == 3'd7) begin
                            state_d = WAIT_DA;
                        end
                    end
                end
                WAIT_DA: begin
                    if (abort_i) begin
                        state_d    = IDLE;
                        byte_cnt_d = 3'd0;
                    end else if (dev_start_i) begin
                        state_d    = COLLECT;
                        byte_cnt_d = 3'd0;
                    end else if (da_valid_i) begin
                        state_d  = WRITE;
                        wvalid_d = 1'b1;
                        index_d  = idx_wrap[IW-1:0];
                        wdata_d  = packed_entry;
                    end
                end
                WRITE: begin
                    state_d = IDLE;
                    count_d = count_q + ONE_W;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            byte_cnt_q <= 3'd0;
            shift_q    <= 64'h0;
            base_q     <= '0;
            count_q    <= '0;
            wvalid_q   <= 1'b0;
            index_q    <= '0;
            wdata_q    <= 128'h0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            base_q     <= base_d;
            count_q    <= count_d;
            wvalid_q   <= wvalid_d;
            index_q    <= index_d;
            wdata_q    <= wdata_d;
        end
    end

    assign dct_write_valid_o = wvalid_q;
    assign dct_index_o       = index_q;
    assign dct_wdata_o       = wdata_q;
    assign busy_o            = (state_q != IDLE);
    assign dev_count_o       = count_q;
    assign full_o            = full;

endmodule
